// File: rtl/ofdm_pkg.sv
// Shared types for the OFDM/FFT datapath: scheduler FSM states and the
// four-component multiplier result record.
package ofdm_pkg;

  localparam int RES_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [RES_W-1:0] minus_i;
    logic [RES_W-1:0] minus_q;
    logic [RES_W-1:0] plus_i;
    logic [RES_W-1:0] plus_q;
  } result_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: the head entry is visible on dout whenever
// valid is high; push and pop in the same cycle are both honoured.
module sync_fifo_fwft #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               count_q, count_d;
  logic                        do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && (count_q != CW'(DEPTH));

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign valid = (count_q != '0);
  assign count = count_q;

  // Upstream credit accounting guarantees a free slot for every push.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/twiddle_scheduler.sv
// Issues one frame of samples to the twiddle multiplier with per-sample phase
// index, credit-limited so every in-flight result has a reserved FIFO slot.
module twiddle_scheduler
  import ofdm_pkg::*;
#(
  parameter int SIZE_DATA_FI  = 3,
  parameter int DATA_FFT_SIZE = 16,
  parameter int MULT_LATENCY  = 4,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [SIZE_DATA_FI-1:0]  stage_step,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_FFT_SIZE-1:0] in_data_i,
  input  logic [DATA_FFT_SIZE-1:0] in_data_q,
  output logic                     mult_en,
  output logic [DATA_FFT_SIZE-1:0] mult_data_i,
  output logic [DATA_FFT_SIZE-1:0] mult_data_q,
  output logic [SIZE_DATA_FI-1:0]  mult_fi,
  input  logic                     mult_valid,
  input  logic [DATA_FFT_SIZE-1:0] mult_minus_i,
  input  logic [DATA_FFT_SIZE-1:0] mult_minus_q,
  input  logic [DATA_FFT_SIZE-1:0] mult_plus_i,
  input  logic [DATA_FFT_SIZE-1:0] mult_plus_q,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_FFT_SIZE-1:0] out_minus_i,
  output logic [DATA_FFT_SIZE-1:0] out_minus_q,
  output logic [DATA_FFT_SIZE-1:0] out_plus_i,
  output logic [DATA_FFT_SIZE-1:0] out_plus_q,
  output logic [SIZE_DATA_FI-1:0]  out_index,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic                     err_unexpected
);

  localparam int N  = 1 << SIZE_DATA_FI;
  localparam int IW = SIZE_DATA_FI + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 1;
  localparam int W  = DATA_FFT_SIZE;

  state_e                  state_q, state_d;
  logic [SIZE_DATA_FI-1:0] acc_q, acc_d;
  logic [SIZE_DATA_FI-1:0] step_q, step_d;
  logic [IW-1:0]           issued_q, issued_d;
  logic [CW-1:0]           inflight_q, inflight_d;
  logic [SIZE_DATA_FI-1:0] out_idx_q, out_idx_d;
  logic                    err_q, err_d;
  logic                    mult_en_q, mult_en_d;
  logic [W-1:0]            mdi_q, mdi_d, mdq_q, mdq_d;
  logic [SIZE_DATA_FI-1:0] mfi_q, mfi_d;

  logic                    accept, push, pop;
  logic [CW-1:0]           fifo_count, fifo_count_next;
  logic                    fifo_valid;
  logic [4*W-1:0]          fifo_head;
  logic [SW-1:0]           committed;

  // The issue register counts as in flight so credit is never overcommitted.
  assign committed = SW'(inflight_q) + SW'(mult_en_q) + SW'(fifo_count);
  assign in_ready  = (state_q == RUN) && (issued_q < IW'(N)) &&
                     (committed < SW'(FIFO_DEPTH));
  assign accept    = in_valid && in_ready;
  assign push      = mult_valid && (inflight_q != '0);
  assign pop       = fifo_valid && out_ready;
  assign fifo_count_next = fifo_count + CW'(push) - CW'(pop);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    step_d     = step_q;
    issued_d   = issued_q;
    out_idx_d  = out_idx_q;
    err_d      = err_q | (mult_valid && (inflight_q == '0));
    inflight_d = inflight_q + CW'(mult_en_q) - CW'(push);
    mult_en_d  = accept;
    mdi_d      = mdi_q;
    mdq_d      = mdq_q;
    mfi_d      = mfi_q;

    if (accept) begin
      mdi_d    = in_data_i;
      mdq_d    = in_data_q;
      mfi_d    = acc_q;
      acc_d    = acc_q + step_q;
      issued_d = issued_q + IW'(1);
    end
    if (pop) out_idx_d = out_idx_q + SIZE_DATA_FI'(1);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          acc_d     = '0;
          issued_d  = '0;
          out_idx_d = '0;
          step_d    = stage_step;
        end
      end
      RUN: begin
        if (issued_d == IW'(N)) state_d = DRAIN;
      end
      DRAIN: begin
        // Look at next-cycle occupancy so done follows the final pop directly.
        if ((inflight_d == '0) && (fifo_count_next == '0)) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      step_q     <= '0;
      issued_q   <= '0;
      inflight_q <= '0;
      out_idx_q  <= '0;
      err_q      <= 1'b0;
      mult_en_q  <= 1'b0;
      mdi_q      <= '0;
      mdq_q      <= '0;
      mfi_q      <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      step_q     <= step_d;
      issued_q   <= issued_d;
      inflight_q <= inflight_d;
      out_idx_q  <= out_idx_d;
      err_q      <= err_d;
      mult_en_q  <= mult_en_d;
      mdi_q      <= mdi_d;
      mdq_q      <= mdq_d;
      mfi_q      <= mfi_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (4*W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({mult_minus_i, mult_minus_q, mult_plus_i, mult_plus_q}),
    .pop   (pop),
    .dout  (fifo_head),
    .valid (fifo_valid),
    .count (fifo_count)
  );

  assign mult_en        = mult_en_q;
  assign mult_data_i    = mdi_q;
  assign mult_data_q    = mdq_q;
  assign mult_fi        = mfi_q;
  assign out_valid      = fifo_valid;
  assign out_minus_i    = fifo_head[4*W-1:3*W];
  assign out_minus_q    = fifo_head[3*W-1:2*W];
  assign out_plus_i     = fifo_head[2*W-1:W];
  assign out_plus_q     = fifo_head[W-1:0];
  assign out_index      = out_idx_q;
  assign out_last       = fifo_valid && (out_idx_q == SIZE_DATA_FI'(N-1));
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign err_unexpected = err_q;

endmodule

// File: tb/tb_twiddle_scheduler.sv
// Self-checking bench: table of frames plus hand sequences for spurious
// multiplier output and mid-frame reset; includes a latency-accurate multiplier model.
module tb_twiddle_scheduler;
  import ofdm_pkg::*;

  localparam int FI = 3;
  localparam int W  = 16;
  localparam int L  = 4;
  localparam int D  = 8;
  localparam int N  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start, in_valid, in_ready, mult_en, mult_valid, out_valid, out_ready;
  logic [FI-1:0] stage_step, mult_fi, out_index;
  logic [W-1:0]  in_data_i, in_data_q, mult_data_i, mult_data_q;
  logic [W-1:0]  mult_minus_i, mult_minus_q, mult_plus_i, mult_plus_q;
  logic [W-1:0]  out_minus_i, out_minus_q, out_plus_i, out_plus_q;
  logic          out_last, busy, done, err_unexpected;
  logic          inj;

  twiddle_scheduler #(.SIZE_DATA_FI(FI), .DATA_FFT_SIZE(W), .MULT_LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stage_step(stage_step),
    .in_valid(in_valid), .in_ready(in_ready), .in_data_i(in_data_i), .in_data_q(in_data_q),
    .mult_en(mult_en), .mult_data_i(mult_data_i), .mult_data_q(mult_data_q), .mult_fi(mult_fi),
    .mult_valid(mult_valid), .mult_minus_i(mult_minus_i), .mult_minus_q(mult_minus_q),
    .mult_plus_i(mult_plus_i), .mult_plus_q(mult_plus_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_minus_i(out_minus_i),
    .out_minus_q(out_minus_q), .out_plus_i(out_plus_i), .out_plus_q(out_plus_q),
    .out_index(out_index), .out_last(out_last), .busy(busy), .done(done),
    .err_unexpected(err_unexpected)
  );

  // Stand-in rotation: any deterministic function of (sample, fi) suffices.
  function automatic result_t mres(input logic [W-1:0] i, input logic [W-1:0] q, input logic [FI-1:0] f);
    result_t r;
    r.minus_i = i - {13'd0, f};
    r.minus_q = q ^ {f, 13'd0};
    r.plus_i  = i + {13'd0, f};
    r.plus_q  = ~q + {f, f, f, f, f, 1'b0};
    return r;
  endfunction

  logic [L-1:0]         pv;
  logic [L-1:0][W-1:0]  pi, pq;
  logic [L-1:0][FI-1:0] pf;
  result_t              mr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0; pi <= '0; pq <= '0; pf <= '0;
    end else begin
      pv <= {pv[L-2:0], mult_en};
      pi <= {pi[L-2:0], mult_data_i};
      pq <= {pq[L-2:0], mult_data_q};
      pf <= {pf[L-2:0], mult_fi};
    end
  end
  assign mr = mres(pi[L-1], pq[L-1], pf[L-1]);
  assign mult_valid = pv[L-1] | inj;
  assign {mult_minus_i, mult_minus_q, mult_plus_i, mult_plus_q} = mr;

  typedef struct {
    logic [FI-1:0]        step;
    logic [N-1:0][FI-1:0] fi;
    int                   vpct;
    int                   rpct;
    int                   hold;
    bit                   fix;
  } vec_t;

  typedef struct {
    result_t       r;
    logic [FI-1:0] idx;
  } exp_t;

  vec_t          tbl[6];
  exp_t          sb[$];
  logic [FI-1:0] fiq[$];
  logic [2*W-1:0] dq[$];
  int            nvec = 0;
  int            nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_vec(input int k, input logic [FI-1:0] step, input logic [N*FI-1:0] fi,
                         input int vp, input int rp, input int hold, input bit fix);
    tbl[k].step = step; tbl[k].fi = fi; tbl[k].vpct = vp;
    tbl[k].rpct = rp; tbl[k].hold = hold; tbl[k].fix = fix;
  endtask

  task automatic run_frame(input vec_t v);
    int sent = 0, popped = 0, dones = 0, maxout = 0, cyc;
    logic [W-1:0] di, dqv;
    exp_t e, ex;
    logic [2*W-1:0] dexp;
    @(negedge clk);
    start = 1'b1; stage_step = v.step;
    @(posedge clk); #1;
    start = 1'b0; stage_step = '0;
    chk("busy_after_start", busy, 1);
    for (cyc = 0; cyc < 3000 && dones == 0; cyc++) begin
      @(negedge clk);
      di  = v.fix ? 16'd749 : W'($urandom);
      dqv = v.fix ? 16'd749 : W'($urandom);
      in_data_i = di; in_data_q = dqv;
      in_valid  = (sent < N) && ($urandom_range(99) < v.vpct);
      out_ready = (cyc >= v.hold) && ($urandom_range(99) < v.rpct);
      #1;
      if (v.hold > 0 && cyc == v.hold) begin
        chk("bp_issued_count", sent, N);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
      end
      if (mult_en) begin
        if (fiq.size() == 0) chk("unexpected_issue", 1, 0);
        else begin
          dexp = dq.pop_front();
          chk("mult_fi", mult_fi, fiq.pop_front());
          chk("mult_data", {mult_data_i, mult_data_q}, dexp);
        end
      end
      if (in_valid && in_ready) begin
        ex.r = mres(di, dqv, v.fi[sent]);
        ex.idx = FI'(sent);
        sb.push_back(ex);
        fiq.push_back(v.fi[sent]);
        dq.push_back({di, dqv});
        sent++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e = sb.pop_front();
          chk("out_data", {out_minus_i, out_minus_q, out_plus_i, out_plus_q}, e.r);
          chk("out_index", out_index, e.idx);
          chk("out_last", out_last, e.idx == FI'(N-1));
        end
        popped++;
      end
      if (done) dones++;
      if (sent - popped > maxout) maxout = sent - popped;
    end
    chk("frame_timeout", dones != 0, 1);
    chk("done_pulses", dones, 1);
    chk("results_popped", popped, N);
    chk("outstanding_le_depth", maxout <= D, 1);
    chk("err_clear", err_unexpected, 0);
    @(negedge clk);
    chk("idle_after_done", {busy, done, out_valid}, 3'b000);
    in_valid = 1'b0; out_ready = 1'b0;
    sb.delete(); fiq.delete(); dq.delete();
  endtask

  initial begin
    int seen;
    start = 0; stage_step = 0; in_valid = 0; in_data_i = 0; in_data_q = 0;
    out_ready = 0; inj = 0;
    set_vec(0, 3'd1, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 100, 100, 0, 1);
    set_vec(1, 3'd3, {3'd5, 3'd2, 3'd7, 3'd4, 3'd1, 3'd6, 3'd3, 3'd0}, 100, 100, 0, 0);
    set_vec(2, 3'd1, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 100, 100, 40, 0);
    set_vec(3, 3'd5, {3'd3, 3'd6, 3'd1, 3'd4, 3'd7, 3'd2, 3'd5, 3'd0}, 50, 50, 0, 0);
    set_vec(4, 3'd7, {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0}, 50, 50, 0, 0);
    set_vec(5, 3'd0, '0, 50, 50, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {busy, in_ready, mult_en, out_valid, out_last, done, err_unexpected}, 7'd0);
    chk("rst_out_index", out_index, 0);
    @(negedge clk); rst_n = 1'b1;

    for (int k = 0; k < 6; k++) run_frame(tbl[k]);

    // Spurious multiplier output while idle.
    @(negedge clk); inj = 1'b1;
    @(posedge clk); #1; inj = 1'b0;
    chk("spurious_err_set", err_unexpected, 1);
    chk("spurious_no_write", out_valid, 0);
    repeat (5) @(negedge clk);
    chk("spurious_err_sticky", err_unexpected, 1);
    chk("spurious_still_empty", out_valid, 0);

    // Mid-frame reset once three samples have been issued.
    @(negedge clk); start = 1'b1; stage_step = 3'd1;
    @(posedge clk); #1; start = 1'b0;
    seen = 0;
    for (int c = 0; c < 50 && seen < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1;
      in_data_i = W'($urandom); in_data_q = W'($urandom);
      #1;
      if (mult_en) seen++;
    end
    chk("rst_mid_reached", seen, 3);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ctrl", {busy, in_ready, mult_en, out_valid, out_last, done, err_unexpected}, 7'd0);
    chk("rst_mid_data", {mult_fi, mult_data_i, out_index, out_minus_i}, 0);
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    run_frame(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
